// File: rtl/pad_share_arbiter.sv
// pad_share_arbiter: round-robin ownership arbiter for a shared group of I/O pads.
// Only one requester drives the pad group at a time. Tristated guard intervals are
// inserted before and after each ownership period.
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   req_i          level ownership request, one bit per requester
//   gnt_o          registered grant, one-hot or zero
//   req_out_i      per-requester pad output values (N_PADS per requester)
//   req_oe_i       per-requester pad output enables
//   req_cfg_i      per-requester pad config (NBIT_PADCFG per pad)
//   req_in_o       pad input values returned to the granted requester only
//   io_out_o       pad output values to the pad ring
//   io_oe_o        pad output enables to the pad ring
//   pad_cfg_o      pad config to the pad ring
//   io_in_i        pad input values from the pad ring
//   busy_o         arbiter is not idle
//   owner_o        index of the current or pending owner
module pad_share_arbiter #(
  parameter int unsigned            N_REQ        = 4,
  parameter int unsigned            N_PADS       = 8,
  parameter int unsigned            NBIT_PADCFG  = 6,
  parameter int unsigned            GUARD_CYCLES = 4,
  parameter logic [NBIT_PADCFG-1:0] CFG_DEFAULT  = '0
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [N_REQ-1:0]                      req_i,
  output logic [N_REQ-1:0]                      gnt_o,
  input  logic [N_REQ*N_PADS-1:0]               req_out_i,
  input  logic [N_REQ*N_PADS-1:0]               req_oe_i,
  input  logic [N_REQ*N_PADS*NBIT_PADCFG-1:0]   req_cfg_i,
  output logic [N_REQ*N_PADS-1:0]               req_in_o,
  output logic [N_PADS-1:0]                     io_out_o,
  output logic [N_PADS-1:0]                     io_oe_o,
  output logic [N_PADS*NBIT_PADCFG-1:0]         pad_cfg_o,
  input  logic [N_PADS-1:0]                     io_in_i,
  output logic                                  busy_o,
  output logic [$clog2(N_REQ)-1:0]              owner_o
);

  localparam int unsigned OW   = $clog2(N_REQ);
  localparam int unsigned CW   = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned CFGW = N_PADS * NBIT_PADCFG;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    OWNED,
    RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q;

  logic [N_PADS-1:0]  out_arr [N_REQ];
  logic [N_PADS-1:0]  oe_arr  [N_REQ];
  logic [CFGW-1:0]    cfg_arr [N_REQ];

  logic               win_found;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      owner_inc;
  int unsigned        cand;
  logic [OW-1:0]      cand_idx;

  // Unpack the flat per-requester buses; drive requester input returns from the grant.
  for (genvar r = 0; r < N_REQ; r++) begin : g_req
    assign out_arr[r] = req_out_i[r*N_PADS +: N_PADS];
    assign oe_arr[r]  = req_oe_i[r*N_PADS +: N_PADS];
    assign cfg_arr[r] = req_cfg_i[r*CFGW +: CFGW];
    assign req_in_o[r*N_PADS +: N_PADS] = gnt_q[r] ? io_in_i : '0;
  end

  // Round-robin winner search starting at rr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = OW'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign owner_inc = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          cnt_d   = CW'(GUARD_CYCLES - 1);
          state_d = SETUP;
        end
      end
      SETUP: begin
        // An aborted setup still advances the pointer so the quitter loses priority.
        if (!req_i[owner_q]) begin
          cnt_d   = CW'(GUARD_CYCLES - 1);
          rr_d    = owner_inc;
          state_d = RELEASE;
        end else if (cnt_q == '0) begin
          gnt_d   = N_REQ'(1) << owner_q;
          rr_d    = owner_inc;
          state_d = OWNED;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OWNED: begin
        if (!req_i[owner_q]) begin
          gnt_d   = '0;
          cnt_d   = CW'(GUARD_CYCLES - 1);
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad-side mux: drive only while OWNED; the owner's config is applied from SETUP on.
  assign io_out_o  = out_arr[owner_q];
  assign io_oe_o   = (state_q == OWNED) ? oe_arr[owner_q] : '0;
  assign pad_cfg_o = (state_q == SETUP || state_q == OWNED) ? cfg_arr[owner_q]
                                                            : {N_PADS{CFG_DEFAULT}};

  assign gnt_o   = gnt_q;
  assign busy_o  = busy_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_pad_share_arbiter.sv
// Testbench for pad_share_arbiter. A timestamp-based reference model tracks
// ownership periods and predicts every output each cycle under directed and random stimulus.
module tb_pad_share_arbiter;

  localparam int unsigned NR   = 4;
  localparam int unsigned NP   = 8;
  localparam int unsigned NB   = 6;
  localparam int unsigned G    = 4;
  localparam int unsigned CFGW = NP * NB;
  localparam logic [NB-1:0] CFGD = 6'h01;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NR-1:0]        req = '0;
  logic [NP-1:0]        out_a [NR];
  logic [NP-1:0]        oe_a  [NR];
  logic [CFGW-1:0]      cfg_a [NR];
  logic [NP-1:0]        io_in = '0;

  logic [NR*NP-1:0]     req_out, req_oe;
  logic [NR*CFGW-1:0]   req_cfg;
  logic [NR-1:0]        gnt;
  logic [NR*NP-1:0]     req_in;
  logic [NP-1:0]        io_out, io_oe;
  logic [CFGW-1:0]      pad_cfg;
  logic                 busy;
  logic [1:0]           owner;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: ownership described by absolute cycle stamps.
  int         cyc = 0;
  bit         m_active = 1'b0;
  logic [1:0] m_owner = '0;
  logic [1:0] m_rr = '0;
  int         m_setup_end = 0;
  int         m_free_at = 0;

  logic [NR-1:0] obs_gnt;
  logic [1:0]    obs_owner;
  logic [NP-1:0] obs_in0;

  always_comb begin
    req_out = '0;
    req_oe  = '0;
    req_cfg = '0;
    for (int r = 0; r < NR; r++) begin
      req_out[r*NP +: NP]     = out_a[r];
      req_oe[r*NP +: NP]      = oe_a[r];
      req_cfg[r*CFGW +: CFGW] = cfg_a[r];
    end
  end

  pad_share_arbiter #(
    .N_REQ(NR), .N_PADS(NP), .NBIT_PADCFG(NB), .GUARD_CYCLES(G), .CFG_DEFAULT(CFGD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt),
    .req_out_i(req_out), .req_oe_i(req_oe), .req_cfg_i(req_cfg), .req_in_o(req_in),
    .io_out_o(io_out), .io_oe_o(io_oe), .pad_cfg_o(pad_cfg), .io_in_i(io_in),
    .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_idle();
    return !m_active && cyc >= m_free_at;
  endfunction
  function automatic bit m_setup();
    return m_active && cyc < m_setup_end;
  endfunction
  function automatic bit m_owned();
    return m_active && cyc >= m_setup_end;
  endfunction

  task automatic model_reset();
    m_active = 1'b0; m_owner = '0; m_rr = '0; m_setup_end = 0; m_free_at = 0; cyc = 0;
  endtask

  // Advance the model by one clock using the requests visible this cycle.
  task automatic model_step();
    bit         found;
    logic [1:0] i;
    found = 1'b0;
    if (m_idle()) begin
      for (int k = 0; k < NR; k++) begin
        i = 2'((int'(m_rr) + k) % NR);
        if (!found && req[i]) begin
          found = 1'b1;
          m_active = 1'b1;
          m_owner = i;
          m_setup_end = cyc + 1 + G;
        end
      end
    end else if (m_setup()) begin
      if (!req[m_owner]) begin
        m_active = 1'b0;
        m_free_at = cyc + 1 + G;
        m_rr = 2'((int'(m_owner) + 1) % NR);
      end else if (cyc == m_setup_end - 1) begin
        m_rr = 2'((int'(m_owner) + 1) % NR);
      end
    end else if (m_owned()) begin
      if (!req[m_owner]) begin
        m_active = 1'b0;
        m_free_at = cyc + 1 + G;
      end
    end
  endtask

  // Called just after a falling edge with inputs applied: check, step model, advance.
  task automatic cycle();
    logic [NR-1:0]    e_gnt;
    logic [NP-1:0]    e_oe;
    logic [CFGW-1:0]  e_cfg;
    logic [NR*NP-1:0] e_in;
    #1;
    e_gnt = m_owned() ? (NR'(1) << m_owner) : '0;
    e_oe  = m_owned() ? oe_a[m_owner] : '0;
    e_cfg = (m_setup() || m_owned()) ? cfg_a[m_owner] : {NP{CFGD}};
    e_in  = '0;
    for (int r = 0; r < NR; r++)
      if (m_owned() && m_owner == 2'(r)) e_in[r*NP +: NP] = io_in;
    check("gnt", 64'(gnt), 64'(e_gnt));
    check("gnt_onehot0", 64'($onehot0(gnt)), 64'(1));
    check("busy", 64'(busy), 64'(!m_idle()));
    check("owner", 64'(owner), 64'(m_owner));
    check("io_oe", 64'(io_oe), 64'(e_oe));
    check("pad_cfg", 64'(pad_cfg), 64'(e_cfg));
    check("io_out", 64'(io_out), 64'(out_a[m_owner]));
    check("req_in", 64'(req_in), 64'(e_in));
    obs_gnt = gnt; obs_owner = owner; obs_in0 = req_in[NP-1:0];
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic randomize_data();
    for (int r = 0; r < NR; r++) begin
      out_a[r] = NP'($urandom());
      oe_a[r]  = NP'($urandom());
      cfg_a[r] = CFGW'({$urandom(), $urandom()});
    end
    io_in = NP'($urandom());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_owner", 64'(owner), 64'(0));
    check("rst_io_oe", 64'(io_oe), 64'(0));
    check("rst_pad_cfg", 64'(pad_cfg), 64'({NP{CFGD}}));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Run cycles until gnt equals want; lat is the cycle index of the first match or -1.
  task automatic run_for_grant(input int bound, input logic [NR-1:0] want, output int lat);
    lat = -1;
    for (int i = 0; i < bound && lat < 0; i++) begin
      cycle();
      if (obs_gnt == want) lat = i;
    end
  endtask

  initial begin
    int lat;
    int run;
    int q[$];
    logic [NR-1:0] prev;
    bit seen;

    for (int r = 0; r < NR; r++) begin
      out_a[r] = '0; oe_a[r] = '0; cfg_a[r] = '0;
    end
    @(negedge clk);

    // Single request latency.
    do_reset();
    randomize_data();
    req = 4'b0001;
    run_for_grant(20, 4'b0001, lat);
    check("single_latency", 64'(lat), 64'(G + 1));
    req = '0;
    repeat (G + 2) cycle();

    // Round robin with all requesters held.
    do_reset();
    randomize_data();
    run = 0;
    prev = '0;
    for (int i = 0; i < 300 && q.size() < 5; i++) begin
      if (m_owned()) begin
        run++;
        req = (run > 3) ? (4'b1111 & ~(NR'(1) << m_owner)) : 4'b1111;
      end else begin
        run = 0;
        req = 4'b1111;
      end
      cycle();
      if (obs_gnt != '0 && prev == '0)
        for (int b = 0; b < NR; b++) if (obs_gnt[b]) q.push_back(b);
      prev = obs_gnt;
    end
    check("rr_count", 64'(q.size()), 64'(5));
    for (int k = 0; k < q.size(); k++) check("rr_order", 64'(q[k]), 64'(k % NR));

    // Abort during setup; next search starts after the aborting requester.
    do_reset();
    randomize_data();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req = (i < 2) ? 4'b0100 : (i == 2) ? 4'b0000 : 4'b1011;
      cycle();
      if (i <= 6 && obs_gnt != '0) seen = 1'b1;
      if (i == 8) check("abort_next_owner", 64'(obs_owner), 64'(3));
    end
    check("abort_no_gnt", 64'(seen), 64'(0));
    req = '0;
    repeat (12) cycle();

    // Non-preemption.
    do_reset();
    randomize_data();
    req = 4'b0010;
    run_for_grant(20, 4'b0010, lat);
    check("nopre_latency", 64'(lat), 64'(G + 1));
    for (int i = 0; i < 6; i++) begin
      req = 4'b0011;
      cycle();
      check("nopre_gnt", 64'(obs_gnt), 64'(4'b0010));
      check("nopre_in0", 64'(obs_in0), 64'(0));
    end
    req = 4'b0001;
    run_for_grant(20, 4'b0001, lat);
    check("nopre_next_latency", 64'(lat), 64'(2 + 2 * G));

    // Asynchronous reset while requester 3 owns with all enables set.
    do_reset();
    randomize_data();
    oe_a[3] = '1;
    req = 4'b1000;
    run_for_grant(20, 4'b1000, lat);
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 64'(gnt), 64'(0));
    check("arst_io_oe", 64'(io_oe), 64'(0));
    check("arst_pad_cfg", 64'(pad_cfg), 64'({NP{CFGD}}));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_for_grant(20, 4'b1000, lat);
    check("arst_regrant_latency", 64'(lat), 64'(G + 1));

    // Owner drops while another requester rises in the same cycle.
    do_reset();
    randomize_data();
    req = 4'b0010;
    run_for_grant(20, 4'b0010, lat);
    repeat (2) cycle();
    req = 4'b0100;
    run_for_grant(30, 4'b0100, lat);
    check("simul_latency", 64'(lat), 64'(2 + 2 * G));

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      randomize_data();
      for (int r = 0; r < NR; r++) begin
        if (req[2'(r)]) begin
          if ($urandom_range(7) == 0) req[2'(r)] = 1'b0;
        end else if ($urandom_range(5) == 0) begin
          req[2'(r)] = 1'b1;
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
